// File: rtl/ifetch_r32i_if.sv
// Fetch-unit bus: PC side, instruction-memory side and decoder side in one bundle.
interface ifetch_r32i_if #(
  parameter int unsigned dataW = 32
);
  // PC side
  logic [dataW-1:0] FetchAddr;
  logic             Flush;
  logic             PCEnable;
  // Instruction-memory side
  logic             MemReq;
  logic [dataW-1:0] MemAddr;
  logic             MemAck;
  logic [dataW-1:0] MemRData;
  // Decoder side
  logic             InstrValid;
  logic             InstrReady;
  logic [dataW-1:0] Instr;
  logic [dataW-1:0] InstrAddr;
  logic             Misaligned;

  // The fetch unit itself
  modport master (
    input  FetchAddr, Flush, MemAck, MemRData, InstrReady,
    output PCEnable, MemReq, MemAddr, InstrValid, Instr, InstrAddr, Misaligned
  );

  // Environment: PC, instruction memory and decoder
  modport slave (
    output FetchAddr, Flush, MemAck, MemRData, InstrReady,
    input  PCEnable, MemReq, MemAddr, InstrValid, Instr, InstrAddr, Misaligned
  );
endinterface

// File: rtl/ifetch_r32i.sv
// Instruction fetch unit: issues one memory request at a time from the PC address,
// buffers returned words in a small FIFO for the decoder, and drops stale data on Flush.
module ifetch_r32i #(
  parameter int unsigned dataW = 32,
  parameter int unsigned Depth = 2
) (
  input  logic          clock,
  input  logic          reset,
  ifetch_r32i_if.master bus
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [dataW-1:0] addr_q, addr_d;
  logic             misaligned_q, misaligned_d;

  logic [dataW-1:0] data_mem_q [Depth];
  logic [dataW-1:0] data_mem_d [Depth];
  logic [dataW-1:0] addr_mem_q [Depth];
  logic [dataW-1:0] addr_mem_d [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    count_q, count_d;

  logic push;
  logic pop;
  logic buf_full;
  logic would_issue;
  logic fetch_aligned;

  assign buf_full      = (count_q == DepthCnt);
  assign fetch_aligned = (bus.FetchAddr[1:0] == 2'b00);
  assign would_issue   = (state_q == StIdle) && !bus.Flush && !misaligned_q && !buf_full;
  assign pop           = (count_q != '0) && bus.InstrReady;

  // Request FSM: issue, wait for ack, or drain a request made stale by Flush
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    misaligned_d = misaligned_q;
    push         = 1'b0;
    case (state_q)
      StIdle: begin
        if (would_issue) begin
          if (fetch_aligned) begin
            addr_d  = bus.FetchAddr;
            state_d = StWait;
          end else begin
            misaligned_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (bus.MemAck) begin
          push    = !bus.Flush;
          state_d = StIdle;
        end else if (bus.Flush) begin
          // Request already on the bus; keep it up until memory answers, then discard
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (bus.MemAck) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.Flush) begin
      misaligned_d = 1'b0;
    end
  end

  // Instruction buffer next state; Flush wins over any same-cycle push or pop
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    data_mem_d = data_mem_q;
    addr_mem_d = addr_mem_q;
    if (bus.Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_mem_d[wr_ptr_q] = bus.MemRData;
        addr_mem_d[wr_ptr_q] = addr_q;
        wr_ptr_d             = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PtrW + 1)'(1);
        2'b01:   count_d = count_q - (PtrW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      misaligned_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < Depth; i++) begin
        data_mem_q[i] <= '0;
        addr_mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      misaligned_q <= misaligned_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      data_mem_q   <= data_mem_d;
      addr_mem_q   <= addr_mem_d;
    end
  end

  assign bus.MemReq     = (state_q == StWait) || (state_q == StDrop);
  assign bus.MemAddr    = addr_q;
  assign bus.PCEnable   = push;
  assign bus.InstrValid = (count_q != '0);
  assign bus.Instr      = data_mem_q[rd_ptr_q];
  assign bus.InstrAddr  = addr_mem_q[rd_ptr_q];
  assign bus.Misaligned = misaligned_q;

endmodule

// File: tb/tb_ifetch_r32i.sv
// Self-checking bench for ifetch_r32i: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_ifetch_r32i;

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  ifetch_r32i_if #(.dataW(32)) bus ();

  ifetch_r32i #(.dataW(32), .Depth(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Park the unit: IDLE, empty buffer, Misaligned clear
  task automatic quiesce();
    bus.Flush      = 1'b1;
    bus.MemAck     = 1'b1;
    bus.InstrReady = 1'b0;
    repeat (3) tick();
    bus.MemAck = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.Flush = 1'b1; bus.MemAck = 1'b0; bus.InstrReady = 1'b0;
    bus.FetchAddr = 32'h100; bus.MemRData = 32'h0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.MemReq, bus.PCEnable, bus.InstrValid, bus.Misaligned} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.MemReq, bus.PCEnable, bus.InstrValid, bus.Misaligned});
    end
    total++;
    if (bus.MemAddr !== 32'h0) begin
      bad++; $display("FAIL reset_memaddr: got %h want 0", bus.MemAddr);
    end
    total++;
    if ({bus.Instr, bus.InstrAddr} !== 64'h0) begin
      bad++; $display("FAIL reset_instr: got %h/%h want 0/0", bus.Instr, bus.InstrAddr);
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.FetchAddr = 32'h100; bus.Flush = 1'b0; bus.MemAck = 1'b0; bus.InstrReady = 1'b0;
    @(negedge clock);
    total++;
    if (bus.MemReq !== 1'b0) begin
      bad++; $display("FAIL basic_idle_req: got %b want 0", bus.MemReq);
    end
    tick();
    bus.MemAck = 1'b1; bus.MemRData = 32'h00500093;
    @(negedge clock);
    total++;
    if ({bus.MemReq, bus.MemAddr} !== {1'b1, 32'h100}) begin
      bad++; $display("FAIL basic_req: got %b/%h want 1/00000100", bus.MemReq, bus.MemAddr);
    end
    total++;
    if ({bus.PCEnable, bus.InstrValid} !== 2'b10) begin
      bad++; $display("FAIL basic_pcen: got %b want 10", {bus.PCEnable, bus.InstrValid});
    end
    tick();
    bus.MemAck = 1'b0; bus.FetchAddr = 32'h104;
    @(negedge clock);
    total++;
    if ({bus.PCEnable, bus.InstrValid, bus.MemReq} !== 3'b010) begin
      bad++; $display("FAIL basic_after: got %b want 010",
                      {bus.PCEnable, bus.InstrValid, bus.MemReq});
    end
    total++;
    if ({bus.Instr, bus.InstrAddr} !== {32'h00500093, 32'h100}) begin
      bad++; $display("FAIL basic_head: got %h/%h want 00500093/00000100",
                      bus.Instr, bus.InstrAddr);
    end
    quiesce();
  endtask

  task automatic test_backpressure();
    bus.Flush = 1'b0; bus.MemAck = 1'b1; bus.InstrReady = 1'b0;
    bus.FetchAddr = 32'h200; bus.MemRData = 32'h0aaa0001;
    repeat (8) tick();
    bus.MemAck = 1'b0; bus.InstrReady = 1'b1;
    @(negedge clock);
    total++;
    if ({bus.MemReq, bus.InstrValid, bus.InstrAddr} !== {2'b01, 32'h200}) begin
      bad++; $display("FAIL bp_full: got %b%b/%h want 01/00000200",
                      bus.MemReq, bus.InstrValid, bus.InstrAddr);
    end
    tick();
    bus.InstrReady = 1'b0;
    @(negedge clock);
    total++;
    if ({bus.MemReq, bus.InstrValid} !== 2'b01) begin
      bad++; $display("FAIL bp_after_pop: got %b want 01", {bus.MemReq, bus.InstrValid});
    end
    tick();
    @(negedge clock);
    total++;
    if (bus.MemReq !== 1'b1) begin
      bad++; $display("FAIL bp_third_req: got %b want 1", bus.MemReq);
    end
    bus.InstrReady = 1'b1;
    tick();
    bus.InstrReady = 1'b0;
    @(negedge clock);
    total++;
    if ({bus.MemReq, bus.InstrValid} !== 2'b10) begin
      bad++; $display("FAIL bp_two_only: got %b want 10", {bus.MemReq, bus.InstrValid});
    end
    quiesce();
  endtask

  task automatic test_flush_wait();
    bus.Flush = 1'b0; bus.MemAck = 1'b0; bus.InstrReady = 1'b0; bus.FetchAddr = 32'h300;
    tick();
    bus.Flush = 1'b1;
    @(negedge clock);
    total++;
    if ({bus.MemReq, bus.PCEnable} !== 2'b10) begin
      bad++; $display("FAIL fw_wait: got %b want 10", {bus.MemReq, bus.PCEnable});
    end
    tick();
    bus.Flush = 1'b0;
    @(negedge clock);
    total++;
    if ({bus.MemReq, bus.MemAddr} !== {1'b1, 32'h300}) begin
      bad++; $display("FAIL fw_drop_held: got %b/%h want 1/00000300", bus.MemReq, bus.MemAddr);
    end
    tick();
    tick();
    bus.MemAck = 1'b1; bus.MemRData = 32'hdeadbeef;
    @(negedge clock);
    total++;
    if ({bus.MemReq, bus.PCEnable} !== 2'b10) begin
      bad++; $display("FAIL fw_drop_ack: got %b want 10", {bus.MemReq, bus.PCEnable});
    end
    tick();
    bus.MemAck = 1'b0; bus.Flush = 1'b1;
    @(negedge clock);
    total++;
    if ({bus.MemReq, bus.InstrValid, bus.PCEnable} !== 3'b000) begin
      bad++; $display("FAIL fw_discarded: got %b want 000",
                      {bus.MemReq, bus.InstrValid, bus.PCEnable});
    end
    quiesce();
  endtask

  task automatic test_flush_ack();
    bus.Flush = 1'b0; bus.MemAck = 1'b0; bus.InstrReady = 1'b0; bus.FetchAddr = 32'h400;
    tick();
    bus.MemAck = 1'b1; bus.MemRData = 32'h11111111;
    tick();
    bus.MemAck = 1'b0; bus.FetchAddr = 32'h404;
    tick();
    bus.Flush = 1'b1; bus.MemAck = 1'b1; bus.MemRData = 32'h22222222;
    @(negedge clock);
    total++;
    if ({bus.InstrValid, bus.PCEnable, bus.MemReq, bus.Instr} !== {3'b101, 32'h11111111})
    begin
      bad++; $display("FAIL fa_before: got %b%b%b/%h want 101/11111111",
                      bus.InstrValid, bus.PCEnable, bus.MemReq, bus.Instr);
    end
    tick();
    bus.MemAck = 1'b0;
    @(negedge clock);
    total++;
    if ({bus.InstrValid, bus.PCEnable, bus.MemReq} !== 3'b000) begin
      bad++; $display("FAIL fa_after: got %b want 000",
                      {bus.InstrValid, bus.PCEnable, bus.MemReq});
    end
    quiesce();
  endtask

  task automatic test_misaligned();
    bus.Flush = 1'b0; bus.MemAck = 1'b0; bus.InstrReady = 1'b0; bus.FetchAddr = 32'h102;
    @(negedge clock);
    total++;
    if (bus.Misaligned !== 1'b0) begin
      bad++; $display("FAIL mis_pre: got %b want 0", bus.Misaligned);
    end
    tick();
    bus.FetchAddr = 32'h104;
    @(negedge clock);
    total++;
    if ({bus.Misaligned, bus.MemReq} !== 2'b10) begin
      bad++; $display("FAIL mis_set: got %b want 10", {bus.Misaligned, bus.MemReq});
    end
    tick();
    @(negedge clock);
    total++;
    if ({bus.Misaligned, bus.MemReq} !== 2'b10) begin
      bad++; $display("FAIL mis_sticky: got %b want 10", {bus.Misaligned, bus.MemReq});
    end
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    @(negedge clock);
    total++;
    if ({bus.Misaligned, bus.MemReq} !== 2'b00) begin
      bad++; $display("FAIL mis_clear: got %b want 00", {bus.Misaligned, bus.MemReq});
    end
    tick();
    @(negedge clock);
    total++;
    if ({bus.MemReq, bus.MemAddr} !== {1'b1, 32'h104}) begin
      bad++; $display("FAIL mis_refetch: got %b/%h want 1/00000104", bus.MemReq, bus.MemAddr);
    end
    quiesce();
  endtask

  task automatic test_reset_in_wait();
    bus.Flush = 1'b0; bus.MemAck = 1'b0; bus.InstrReady = 1'b0; bus.FetchAddr = 32'h500;
    tick();
    @(negedge clock);
    total++;
    if (bus.MemReq !== 1'b1) begin
      bad++; $display("FAIL rw_req: got %b want 1", bus.MemReq);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.MemReq, bus.MemAddr} !== 33'h0) begin
      bad++; $display("FAIL rw_async: got %b/%h want 0/0", bus.MemReq, bus.MemAddr);
    end
    tick();
    bus.MemAck = 1'b1; bus.MemRData = 32'h33333333;
    @(negedge clock);
    total++;
    if ({bus.MemReq, bus.PCEnable, bus.InstrValid, bus.Misaligned, bus.Instr, bus.InstrAddr}
        !== 68'h0) begin
      bad++; $display("FAIL rw_ack_ignored: got %b%b%b%b/%h/%h want 0000/0/0",
                      bus.MemReq, bus.PCEnable, bus.InstrValid, bus.Misaligned,
                      bus.Instr, bus.InstrAddr);
    end
    tick();
    reset = 1'b0; bus.Flush = 1'b1;
    @(negedge clock);
    total++;
    if ({bus.InstrValid, bus.MemReq} !== 2'b00) begin
      bad++; $display("FAIL rw_released: got %b want 00", {bus.InstrValid, bus.MemReq});
    end
    tick();
    bus.MemAck = 1'b0;
  endtask

  // Random traffic against a transaction-level model: one outstanding request,
  // a queue of buffered {addr, data}, and a sticky misalignment flag.
  task automatic test_random();
    ent_t        q[$];
    bit          outst = 1'b0;
    bit          stale = 1'b0;
    bit          mis   = 1'b0;
    logic [31:0] raddr = 32'h0;
    logic [31:0] fa;
    logic [31:0] rd;
    bit          fl, ak, rdy, exp_pc, exp_valid;
    int          n;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fl  = ($urandom_range(0, 15) == 0);
      ak  = outst && ($urandom_range(0, 2) != 0);
      rd  = $urandom();
      rdy = ($urandom_range(0, 1) == 1);
      fa  = $urandom() & 32'hffff_fffc;
      if ($urandom_range(0, 31) == 0) fa[1:0] = 2'($urandom_range(1, 3));
      bus.Flush = fl; bus.MemAck = ak; bus.MemRData = rd;
      bus.InstrReady = rdy; bus.FetchAddr = fa;
      exp_pc    = outst && !stale && ak && !fl;
      exp_valid = (q.size() != 0);
      @(negedge clock);
      total++;
      if ({bus.MemReq, bus.PCEnable, bus.InstrValid, bus.Misaligned}
          !== {outst, exp_pc, exp_valid, mis}) begin
        bad++; $display("FAIL rnd_flags cyc=%0d: got %b want %b", cyc,
                        {bus.MemReq, bus.PCEnable, bus.InstrValid, bus.Misaligned},
                        {outst, exp_pc, exp_valid, mis});
      end
      total++;
      if (bus.MemAddr !== raddr) begin
        bad++; $display("FAIL rnd_memaddr cyc=%0d: got %h want %h", cyc, bus.MemAddr, raddr);
      end
      if (exp_valid) begin
        total++;
        if ({bus.InstrAddr, bus.Instr} !== q[0]) begin
          bad++; $display("FAIL rnd_head cyc=%0d: got %h/%h want %h/%h", cyc,
                          bus.InstrAddr, bus.Instr, q[0].a, q[0].d);
        end
      end
      n = q.size();
      if (fl) begin
        q.delete();
      end else begin
        if (exp_valid && rdy) void'(q.pop_front());
        if (exp_pc) q.push_back({raddr, rd});
      end
      if (outst) begin
        if (ak) outst = 1'b0;
        else if (fl) stale = 1'b1;
      end else if (!fl && !mis && n < DEPTH) begin
        if (fa[1:0] == 2'b00) begin
          outst = 1'b1; stale = 1'b0; raddr = fa;
        end else begin
          mis = 1'b1;
        end
      end
      if (fl) mis = 1'b0;
      tick();
    end
  endtask

  initial begin
    bus.FetchAddr = 32'h0; bus.Flush = 1'b1; bus.MemAck = 1'b0;
    bus.MemRData = 32'h0; bus.InstrReady = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_wait();
    test_flush_ack();
    test_misaligned();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_r32i.md
IFETCH_R32I -- requirements
Module: ifetch_r32i

Interface
REQ-001 Parameter dataW, default 32, SHALL set the address and instruction width.
REQ-002 Parameter Depth, default 2, SHALL set the instruction buffer depth in entries (power of two, >=2).
REQ-003 clock  in  1  SHALL be the rising-edge clock.
REQ-004 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 FetchAddr  in  dataW  SHALL carry the program address from the PC.
REQ-006 Flush  in  1  SHALL indicate that a branch was taken and buffered or in-flight instructions are stale.
REQ-007 PCEnable  out  1  SHALL tell the PC it may advance; one-cycle pulse per accepted fetch.
REQ-008 MemReq  out  1  SHALL be the instruction-memory request.
REQ-009 MemAddr  out  dataW  SHALL be the request address, registered at issue.
REQ-010 MemAck  in  1  SHALL be the single-cycle memory acknowledge; MemRData is valid in the same cycle.
REQ-011 MemRData  in  dataW  SHALL be the instruction word returned by memory.
REQ-012 InstrValid  out  1  SHALL indicate that the buffer head holds a valid instruction.
REQ-013 InstrReady  in  1  SHALL indicate that the decoder consumes the head this cycle.
REQ-014 Instr  out  dataW  SHALL be the buffer-head instruction word.
REQ-015 InstrAddr  out  dataW  SHALL be the address of the buffer-head instruction.
REQ-016 Misaligned  out  1  SHALL be a sticky fault flag for FetchAddr[1:0] != 0.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT, DROP.
REQ-018 MemReq SHALL be high exactly when the state is WAIT or DROP; MemAddr SHALL stay stable until MemAck.
REQ-019 The block SHALL issue from IDLE when Flush=0, Misaligned=0, FetchAddr[1:0]=0 and buffer count < Depth: at the edge, capture MemAddr<=FetchAddr and go to WAIT.
REQ-020 If a would-be issue has FetchAddr[1:0]!=0, the block SHALL set Misaligned, stay in IDLE and issue no request.
REQ-021 Misaligned SHALL remain set until Flush or reset, and SHALL block all issue while set.
REQ-022 In WAIT with MemAck=1 and Flush=0, the block SHALL push {MemAddr, MemRData} into the buffer, assert PCEnable combinationally that cycle, and go to IDLE.
REQ-023 In WAIT with Flush=1 and MemAck=0, the block SHALL go to DROP with MemReq held high.
REQ-024 In WAIT with Flush=1 and MemAck=1, the block SHALL discard the data, keep PCEnable low, and go to IDLE.
REQ-025 In DROP with MemAck=1, the block SHALL discard the data, keep PCEnable low, and go to IDLE.
REQ-026 PCEnable SHALL be low in every other case.
REQ-027 Buffer behaviour: FIFO of Depth entries with wrap-around pointers.
  - InstrValid = (count != 0); Instr and InstrAddr show the head entry.
  - A pop occurs when InstrValid && InstrReady.
  - A push and a pop in the same cycle SHALL leave count unchanged.
REQ-028 Flush SHALL empty the buffer at the next edge; Flush overrides any same-cycle push or pop.
REQ-029 At most one request SHALL be outstanding; issue SHALL never occur while count = Depth.
REQ-030 Fetch latency: FetchAddr is captured at edge N; MemReq is high in cycle N+1; if MemAck arrives in cycle N+1, InstrValid is high in cycle N+2. Peak throughput is one instruction per two cycles.

Reset
REQ-031 Reset SHALL force, asynchronously: state IDLE, MemReq 0, MemAddr 0, buffer empty (InstrValid 0, Instr 0, InstrAddr 0), PCEnable 0, Misaligned 0.
REQ-032 Reset asserted during WAIT or DROP SHALL abandon the request; any later MemAck SHALL be ignored while in IDLE.

Verification
REQ-033 Basic fetch: FetchAddr=0x100, MemAck one cycle after MemReq, MemRData=0x00500093 -> PCEnable pulses once; next cycle InstrValid=1, Instr=0x00500093, InstrAddr=0x100.
REQ-034 Backpressure: InstrReady=0, three fetches offered -> exactly 2 entries buffered, MemReq stays low; one pop -> a third request is issued.
REQ-035 Flush mid-request: Flush in WAIT, MemAck three cycles later -> DROP entered, data discarded, PCEnable never pulses, InstrValid=0.
REQ-036 Flush coincident with MemAck while the buffer holds 1 entry -> buffer empty next cycle, PCEnable=0, state IDLE.
REQ-037 Misaligned: FetchAddr=0x102 -> Misaligned=1, no MemReq; Flush with FetchAddr=0x104 -> Misaligned clears and a fetch to 0x104 proceeds.
REQ-038 Reset in WAIT: assert reset, then MemAck -> all outputs at reset values and no entry pushed.
